// File: rtl/kalman_pkg.sv
// Shared constants, FSM encoding and fixed-point helpers
// for the alpha-beta tracker.
package kalman_pkg;

  localparam int ONE_FI     = 32768;
  localparam int TSTEP_DEF  = 1092;
  localparam int ALPHA_DEF  = 16384;
  localparam int BETA_T_DEF = 8192;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_PRED,
    S_INNOV,
    S_UPD_X,
    S_UPD_V,
    S_DONE
  } state_e;

  // Callers pass a wide value and size-cast the result to w bits.
  function automatic logic signed [127:0] sat(
    input logic signed [127:0] v,
    input int                  w
  );
    if (v > ((128'sd1 <<< (w - 1)) - 128'sd1))
      return (128'sd1 <<< (w - 1)) - 128'sd1;
    if (v < -(128'sd1 <<< (w - 1)))
      return -(128'sd1 <<< (w - 1));
    return v;
  endfunction

  function automatic logic signed [127:0] clamp_pix(
    input logic signed [127:0] x,
    input int                  f,
    input int                  dw
  );
    if ((x >>> f) < 128'sd0)
      return 128'sd0;
    if ((x >>> f) > ((128'sd1 <<< dw) - 128'sd1))
      return (128'sd1 <<< dw) - 128'sd1;
    return x >>> f;
  endfunction

endpackage

// File: rtl/kalman_fx_mac.sv
// Saturating fixed-point multiply-add:
// y = sat(a + floor(b*c / 2^ARCH_F)).
module kalman_fx_mac
  import kalman_pkg::*;
#(
  parameter int ARCH_W = 32,
  parameter int ARCH_F = 15
) (
  input  logic signed [ARCH_W-1:0] a_i,
  input  logic signed [ARCH_W-1:0] b_i,
  input  logic signed [ARCH_W-1:0] c_i,
  output logic signed [ARCH_W-1:0] y_o
);

  logic signed [2*ARCH_W-1:0] prod;
  logic signed [2*ARCH_W:0]   sum;

  assign prod = (2*ARCH_W)'(b_i) * (2*ARCH_W)'(c_i);
  assign sum  = (2*ARCH_W+1)'(a_i)
              + (2*ARCH_W+1)'(prod >>> ARCH_F);
  assign y_o  = ARCH_W'(sat(128'(sum), ARCH_W));

endmodule

// File: rtl/kalman_ab_tracker.sv
// Steady-state alpha-beta tracker, one axis step per cycle
// through a single shared multiply-add unit.
module kalman_ab_tracker
  import kalman_pkg::*;
#(
  parameter int DISP_WIDTH = 11,
  parameter int NUM_AXES   = 2,
  parameter int ARCH_W     = 32,
  parameter int ARCH_F     = 15,
  parameter int TSTEP      = TSTEP_DEF,
  parameter int ALPHA      = ALPHA_DEF,
  parameter int BETA_T     = BETA_T_DEF,
  parameter int GATE       = 64,
  parameter int MAX_COAST  = 8
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic                           meas_valid,
  output logic                           meas_ready,
  input  logic                           meas_present,
  input  logic [NUM_AXES*DISP_WIDTH-1:0] z,
  output logic                           est_valid,
  output logic [NUM_AXES*DISP_WIDTH-1:0] est,
  output logic                           lost,
  output logic [$clog2(MAX_COAST+1)-1:0] coast_cnt
);

  localparam int CW  = $clog2(MAX_COAST + 1);
  localparam int AXW = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam longint GATE_FX = longint'(GATE) <<< ARCH_F;

  typedef logic signed [ARCH_W-1:0] word_t;

  state_e                         state_q, state_d;
  logic [AXW-1:0]                 ax_q, ax_d;
  word_t                          x_q [NUM_AXES];
  word_t                          v_q [NUM_AXES];
  word_t                          xp_q, r_q;
  logic [NUM_AXES*DISP_WIDTH-1:0] z_q, est_q, est_d;
  logic                           pres_q, acc_q, any_q;
  logic                           lost_q, est_valid_q;
  logic [CW-1:0]                  coast_q, coast_inc;
  word_t                          mac_a, mac_b, mac_c, mac_y;
  word_t                          zf, r_d;
  logic [DISP_WIDTH-1:0]          zc;
  logic                           last, acq, acc;

  assign last = (ax_q == AXW'(NUM_AXES - 1));
  assign acq  = lost_q & pres_q;
  assign zc   = z_q[int'(ax_q)*DISP_WIDTH +: DISP_WIDTH];
  assign zf   = word_t'({zc, {ARCH_F{1'b0}}});
  assign r_d  = word_t'(sat(128'(zf) - 128'(xp_q), ARCH_W));
  assign acc  = pres_q & ~lost_q
              & (longint'(r_d) >= -GATE_FX)
              & (longint'(r_d) <= GATE_FX);
  assign coast_inc = (coast_q == CW'(MAX_COAST))
                   ? coast_q : coast_q + CW'(1);

  always_comb begin
    mac_a = x_q[ax_q];
    mac_b = word_t'(TSTEP);
    mac_c = v_q[ax_q];
    unique case (1'b1)
      (state_q == S_UPD_X): begin
        mac_a = xp_q;
        mac_b = word_t'(ALPHA);
        mac_c = r_q;
      end
      (state_q == S_UPD_V): begin
        mac_a = v_q[ax_q];
        mac_b = word_t'(BETA_T);
        mac_c = r_q;
      end
      default: ;
    endcase
  end

  kalman_fx_mac #(
    .ARCH_W(ARCH_W),
    .ARCH_F(ARCH_F)
  ) u_mac (
    .a_i(mac_a),
    .b_i(mac_b),
    .c_i(mac_c),
    .y_o(mac_y)
  );

  always_comb begin
    est_d = '0;
    for (int i = 0; i < NUM_AXES; i++)
      est_d[i*DISP_WIDTH +: DISP_WIDTH] =
        DISP_WIDTH'(clamp_pix(128'(x_q[i]), ARCH_F, DISP_WIDTH));
  end

  always_comb begin
    state_d = state_q;
    ax_d    = ax_q;
    unique case (1'b1)
      (state_q == S_INIT):  state_d = S_IDLE;
      (state_q == S_IDLE):
        if (meas_valid) begin
          state_d = S_PRED;
          ax_d    = '0;
        end
      (state_q == S_PRED):  state_d = S_INNOV;
      (state_q == S_INNOV): state_d = S_UPD_X;
      (state_q == S_UPD_X): state_d = S_UPD_V;
      (state_q == S_UPD_V):
        if (last) state_d = S_DONE;
        else begin
          state_d = S_PRED;
          ax_d    = ax_q + AXW'(1);
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_INIT;
      ax_q    <= '0;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
    end
  end

  // Frame results land on the last UPD_V edge so they show in DONE.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_AXES; i++) begin
        x_q[i] <= '0;
        v_q[i] <= '0;
      end
      xp_q        <= '0;
      r_q         <= '0;
      z_q         <= '0;
      pres_q      <= 1'b0;
      acc_q       <= 1'b0;
      any_q       <= 1'b0;
      est_q       <= '0;
      est_valid_q <= 1'b0;
      lost_q      <= 1'b1;
      coast_q     <= '0;
    end else begin
      est_valid_q <= 1'b0;
      unique case (1'b1)
        (state_q == S_INIT):
          for (int i = 0; i < NUM_AXES; i++) begin
            x_q[i] <= '0;
            v_q[i] <= '0;
          end
        (state_q == S_IDLE):
          if (meas_valid) begin
            z_q    <= z;
            pres_q <= meas_present;
            any_q  <= 1'b0;
          end
        (state_q == S_PRED): xp_q <= mac_y;
        (state_q == S_INNOV): begin
          r_q   <= r_d;
          acc_q <= acc;
          any_q <= any_q | acc;
        end
        (state_q == S_UPD_X):
          if (acq) x_q[ax_q] <= zf;
          else if (!lost_q) x_q[ax_q] <= acc_q ? mac_y : xp_q;
        (state_q == S_UPD_V): begin
          if (acq) v_q[ax_q] <= '0;
          else if (acc_q) v_q[ax_q] <= mac_y;
          if (last) begin
            est_valid_q <= 1'b1;
            est_q       <= est_d;
            if (acq) begin
              lost_q  <= 1'b0;
              coast_q <= '0;
            end else if (!lost_q) begin
              if (any_q) coast_q <= '0;
              else begin
                coast_q <= coast_inc;
                if (coast_inc == CW'(MAX_COAST)) lost_q <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign meas_ready = (state_q == S_IDLE);
  assign est_valid  = est_valid_q;
  assign est        = est_q;
  assign lost       = lost_q;
  assign coast_cnt  = coast_q;

endmodule

// File: tb/tb_kalman_ab_tracker.sv
// Directed plus randomized frames checked against a
// plain-arithmetic model of the alpha-beta tracker.
module tb_kalman_ab_tracker;

  localparam int DW = 11;
  localparam int NA = 2;
  localparam int MC = 3;
  localparam longint TS = 32768;
  localparam longint AL = 16384;
  localparam longint BT = 8192;
  localparam longint GT = 64;

  logic            clk = 1'b0;
  logic            aresetn = 1'b0;
  logic            meas_valid = 1'b0;
  logic            meas_present = 1'b0;
  logic [NA*DW-1:0] z = '0;
  logic            meas_ready, est_valid, lost;
  logic [NA*DW-1:0] est;
  logic [1:0]      coast_cnt;

  int errs = 0;
  int checks = 0;

  longint mx [NA];
  longint mv [NA];
  longint mest [NA];
  int     mlost, mcoast;

  always #5 clk = ~clk;

  kalman_ab_tracker #(
    .DISP_WIDTH(DW), .NUM_AXES(NA), .ARCH_W(32), .ARCH_F(15),
    .TSTEP(32768), .ALPHA(16384), .BETA_T(8192),
    .GATE(64), .MAX_COAST(MC)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .meas_valid(meas_valid), .meas_ready(meas_ready),
    .meas_present(meas_present), .z(z),
    .est_valid(est_valid), .est(est),
    .lost(lost), .coast_cnt(coast_cnt)
  );

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint mac(input longint a, input longint b,
                                 input longint c);
    return sat32(a + ((b * c) >>> 15));
  endfunction

  function automatic longint pix(input longint x);
    longint p;
    p = x >>> 15;
    if (p < 0) return 0;
    if (p > 2047) return 2047;
    return p;
  endfunction

  task automatic model_rst();
    for (int i = 0; i < NA; i++) begin
      mx[i] = 0; mv[i] = 0; mest[i] = 0;
    end
    mlost = 1;
    mcoast = 0;
  endtask

  task automatic model_frame(input bit pres, input int z0,
                             input int z1);
    longint zz [NA];
    longint xp, r;
    bit any;
    zz[0] = longint'(z0) <<< 15;
    zz[1] = longint'(z1) <<< 15;
    if (mlost == 1 && pres) begin
      for (int i = 0; i < NA; i++) begin
        mx[i] = zz[i]; mv[i] = 0;
      end
      mlost = 0;
      mcoast = 0;
    end else if (mlost == 0) begin
      any = 0;
      for (int i = 0; i < NA; i++) begin
        xp = mac(mx[i], TS, mv[i]);
        r  = sat32(zz[i] - xp);
        if (pres && r >= -(GT <<< 15) && r <= (GT <<< 15)) begin
          mx[i] = mac(xp, AL, r);
          mv[i] = mac(mv[i], BT, r);
          any = 1;
        end else
          mx[i] = xp;
      end
      if (any) mcoast = 0;
      else begin
        if (mcoast < MC) mcoast++;
        if (mcoast == MC) mlost = 1;
      end
    end
    for (int i = 0; i < NA; i++) mest[i] = pix(mx[i]);
  endtask

  task automatic run_frame(input bit pres, input int z0,
                           input int z1);
    int n;
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (meas_ready) begin ok = 1; break; end
    end
    chk("ready_wait", ok, 1);
    meas_valid = 1'b1;
    meas_present = pres;
    z = {z1[DW-1:0], z0[DW-1:0]};
    @(posedge clk);
    #1 meas_valid = 1'b0;
    n = 0;
    while (!est_valid && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", n, 4 * NA);
    model_frame(pres, z0, z1);
    chk("est0", est[DW-1:0], mest[0]);
    chk("est1", est[2*DW-1:DW], mest[1]);
    chk("lost", lost, mlost);
    chk("coast", coast_cnt, mcoast);
    chk("rdy_done", meas_ready, 0);
    @(posedge clk);
    #1;
    chk("pulse_end", est_valid, 0);
    chk("rdy_back", meas_ready, 1);
  endtask

  initial begin
    int z0, z1;
    bit seen;
    model_rst();
    #12;
    chk("rst_rdy", meas_ready, 0);
    chk("rst_ev", est_valid, 0);
    chk("rst_est", est, 0);
    chk("rst_lost", lost, 1);
    chk("rst_coast", coast_cnt, 0);
    @(negedge clk) aresetn = 1'b1;
    #1 chk("init_rdy", meas_ready, 0);
    @(posedge clk);
    #1 chk("rdy_rise", meas_ready, 1);

    run_frame(1, 100, 200);
    chk("s1_e0", est[DW-1:0], 100);
    chk("s1_e1", est[2*DW-1:DW], 200);
    run_frame(1, 110, 200);
    chk("s2_e0", est[DW-1:0], 105);
    run_frame(0, 0, 0);
    chk("s3_e0", est[DW-1:0], 107);
    chk("s3_coast", coast_cnt, 1);
    run_frame(1, 500, 201);
    chk("s4_e0", est[DW-1:0], 110);
    chk("s4_e1", est[2*DW-1:DW], 200);
    chk("s4_coast", coast_cnt, 0);
    repeat (3) run_frame(0, 0, 0);
    chk("s5_coast", coast_cnt, 3);
    chk("s5_lost", lost, 1);
    run_frame(1, 300, 50);
    chk("s6_e0", est[DW-1:0], 300);
    chk("s6_e1", est[2*DW-1:DW], 50);
    chk("s6_lost", lost, 0);

    repeat (3) run_frame(0, 0, 0);
    run_frame(1, 4, 4);
    run_frame(1, 0, 0);
    repeat (3) run_frame(0, 0, 0);
    chk("neg_clamp", est[DW-1:0], 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        z0 = $urandom_range(0, 2047);
        z1 = $urandom_range(0, 2047);
      end else begin
        z0 = int'(mest[0]) + $urandom_range(0, 200) - 100;
        z1 = int'(mest[1]) + $urandom_range(0, 200) - 100;
        if (z0 < 0) z0 = 0;
        if (z0 > 2047) z0 = 2047;
        if (z1 < 0) z1 = 0;
        if (z1 > 2047) z1 = 2047;
      end
      run_frame($urandom_range(0, 4) != 0, z0, z1);
    end

    run_frame(1, 20, 30);
    @(negedge clk);
    meas_valid = 1'b1;
    meas_present = 1'b1;
    z = {11'd40, 11'd40};
    @(posedge clk);
    #1 meas_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 aresetn = 1'b0;
    #1;
    model_rst();
    chk("ar_est", est, 0);
    chk("ar_lost", lost, 1);
    chk("ar_ev", est_valid, 0);
    chk("ar_rdy", meas_ready, 0);
    chk("ar_coast", coast_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) aresetn = 1'b1;
    #1 chk("ar_init_rdy", meas_ready, 0);
    seen = 0;
    @(posedge clk);
    #1 chk("ar_rdy_rise", meas_ready, 1);
    repeat (12) begin
      @(posedge clk);
      #1 seen |= est_valid;
    end
    chk("ar_no_pulse", seen, 0);
    run_frame(1, 7, 9);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/kalman_ab_tracker.md
# kalman_ab_tracker

- Parametrised steady-state Kalman (alpha-beta) tracker for the object-tracking pipeline.
- Filters one measured position per frame on NUM_AXES independent constant-velocity axes, with a full predict and update step.
- Adds handshaked input and output, predict-only coasting on missing or gated measurements, track-loss detection with re-acquisition, and clamped pixel outputs.
- Sits between the centroid detector and the display overlay. Uses one time-shared fixed-point multiply-add unit.

## Interface
- DISP_WIDTH, 11: pixel coordinate width per axis.
- NUM_AXES, 2: number of independent axes, 1..4.
- ARCH_W, 32: internal two's-complement word width.
- ARCH_F, 15: fractional bits.
- TSTEP, 1092: frame period in Q(ARCH_F); 1092 ≈ 1/30.
- ALPHA, 16384: position gain in Q(ARCH_F).
- BETA_T, 8192: velocity gain beta/T in Q(ARCH_F).
- GATE, 64: maximum |innovation| accepted, in pixels.
- MAX_COAST, 8: consecutive coasted frames before track loss.

Ports:
- clk, in, 1: clock.
- aresetn, in, 1: reset, asynchronous, active-low.
- meas_valid, in, 1: measurement frame offered.
- meas_ready, out, 1: block can accept a frame.
- meas_present, in, 1: 1 = z holds a detection; 0 = coast this frame.
- z, in, NUM_AXES*DISP_WIDTH: unsigned positions, axis 0 in the LSBs.
- est_valid, out, 1: one-cycle pulse, estimate updated.
- est, out, NUM_AXES*DISP_WIDTH: filtered positions.
- lost, out, 1: no track held.
- coast_cnt, out, $clog2(MAX_COAST+1): consecutive coasted frames.

## Operation
- Per-axis state: position x and velocity v, each ARCH_W Q(ARCH_F).
- All arithmetic is two's complement and saturates to ARCH_W.
- Multiply: full 2*ARCH_W product, arithmetic shift right by ARCH_F (floor), then saturate.
- FSM states: INIT → IDLE → per axis (PRED → INNOV → UPD_X → UPD_V) → DONE → IDLE.
- INIT: clears all state. Lasts one cycle after reset release.
- IDLE: meas_ready=1. A frame is accepted when meas_valid && meas_ready; z and meas_present are captured in that cycle.
- PRED: xp = x + TSTEP*v.
- INNOV: r = (z<<ARCH_F) − xp. The axis is accepted if meas_present && |r| ≤ GATE<<ARCH_F.
- UPD_X: if accepted, x = xp + ALPHA*r; otherwise x = xp.
- UPD_V: if accepted, v = v + BETA_T*r; otherwise v is unchanged.
- Acquire mode applies when lost=1 and meas_present=1. Every axis is set to x = z<<ARCH_F, v = 0, with no gating. lost is cleared and coast_cnt is zeroed. Axis cycles still elapse, so timing is unchanged.
- lost=1 with meas_present=0: state is held, est is unchanged, coast_cnt is unchanged.
- Frame bookkeeping: if no axis was accepted, coast_cnt increments, saturating at MAX_COAST. Otherwise coast_cnt clears.
- Track loss: when coast_cnt reaches MAX_COAST, lost is set in DONE.
- Output: est per axis is the integer part of x, clamped to [0, 2^DISP_WIDTH−1]. It is registered in DONE.

## Timing
- Reset values: meas_ready=0, est_valid=0, est=0, lost=1, coast_cnt=0, FSM=INIT.
- meas_ready rises one cycle after reset release.
- Latency: handshake in cycle k gives est_valid high in cycle k+1+4*NUM_AXES. For NUM_AXES=2 this is k+9.
- est, lost and coast_cnt all change in the same cycle that est_valid is high, and hold afterwards.
- meas_ready is low from k+1 through the DONE cycle and returns high the cycle after.
- Throughput: one frame per 4*NUM_AXES+2 cycles.
- meas_valid while meas_ready=0 is ignored; no buffering.
- Asserting aresetn mid-frame aborts the frame immediately and returns all outputs to their reset values.

## Structure
- Package kalman_pkg holds:
  - the fixed-point constants (ONE_FI, and TSTEP/ALPHA/BETA_T defaults);
  - the FSM state enum;
  - sat and clamp-to-pixel functions.
- Sub-module kalman_fx_mac: combinational y = sat(a + ((b*c)>>>ARCH_F)). PRED, UPD_X and UPD_V share one instance through operand muxes. INNOV uses a saturating subtractor.

## Test plan
All scenarios use TSTEP=32768 (1.0), ALPHA=16384 (0.5), BETA_T=8192 (0.25), GATE=64, MAX_COAST=3, NUM_AXES=2.

- Reset, then frame present z=(100,200) → est_valid 9 cycles after the handshake, est=(100,200), lost=0, coast_cnt=0.
- Next frame z=(110,200) → est=(105,200). Internal v0=2.5, v1=0.
- Next frame with meas_present=0 → est=(107,200) (107.5 floored), coast_cnt=1.
- Frame z=(500,201) → axis 0 gated and coasts to 110, axis 1 updates to 200 (200.5 floored). coast_cnt=0.
- Three coast frames → coast_cnt=3, lost=1. Next frame z=(300,50) → est=(300,50), lost=0.
- Negative velocity driving x below 0 → est axis reads 0. aresetn pulsed during UPD_X → est=0, lost=1, est_valid never pulses, meas_ready high one cycle after release.
